channel_framer: RTL and testbench
=================================

# channel_framer

Parametrised multi-channel sample framer feeding the processing-system readout path. On each sync strobe it snapshots `NUM_CH` parallel channel words and writes one frame (header word, then one word per channel) into an internal word FIFO. The FIFO drains over a valid/ready stream with a last-word marker. Frames that cannot be accepted whole are dropped and counted; frames are never emitted partially.

## Interface
- `NUM_CH`, 8: channels per frame, 1..64.
- `DATA_W`, 32: channel and stream word width, at least 16.
- `FIFO_DEPTH`, 32: FIFO depth in words. Must be a power of 2 and at least `NUM_CH+1`; elaboration fails otherwise.

- `clk`, in, 1: sole clock, rising edge.
- `rst_ni`, in, 1: reset, asynchronous assert, active-low.
- `en_i`, in, 1: framing enable; while low, `sync_i` is ignored.
- `sync_i`, in, 1: single-cycle capture strobe.
- `ch_data_i`, in, `NUM_CH*DATA_W`: channel c occupies bits `[c*DATA_W +: DATA_W]`.
- `m_tdata_o`, out, `DATA_W`: stream data.
- `m_tvalid_o`, out, 1: stream valid.
- `m_tlast_o`, out, 1: high on the last word of a frame (channel `NUM_CH-1`).
- `m_tready_i`, in, 1: stream ready.
- `busy_o`, out, 1: frame writer active.
- `drop_cnt_o`, out, 16: dropped-frame count, saturates at 16'hFFFF.
- `level_o`, out, `$clog2(FIFO_DEPTH)+1`: FIFO occupancy in words.

## Operation
- Writer FSM has two states.
  - IDLE: waits for a strobe.
  - WRITE: emits `NUM_CH+1` words, tracked by word index `wi` running 0..`NUM_CH`.
- Accept condition, evaluated at a clock edge: `en_i & sync_i & (state==IDLE) & (FIFO_DEPTH - level >= NUM_CH+1)`.
  - Occupancy used is the value before that edge's read.
  - On accept: latch all channels into a snapshot register, latch `seq`, go to WRITE with `wi=0`.
- Reject condition: `en_i & sync_i` without accept. Frame is dropped and `drop_cnt_o` increments, saturating.
- WRITE phase, one FIFO write per cycle:
  - `wi=0`: header word `{8'hA5, seq[DATA_W-9:0]}`.
  - `wi=c+1`: snapshot channel c.
  - `wi=NUM_CH`: tlast bit set; return to IDLE and increment `seq`, which wraps modulo 2^(`DATA_W-8`).
- Each FIFO entry stores `DATA_W+1` bits: data plus tlast.
- The FIFO is first-word-fall-through.
  - `m_tvalid_o = level != 0`.
  - A read occurs when `m_tvalid_o & m_tready_i`.
  - A simultaneous read and write leaves the level unchanged.
  - Space was reserved at accept, so a write never overflows.
- `m_tdata_o` and `m_tlast_o` must stay stable while `m_tvalid_o & !m_tready_i`.
- `en_i` falling during WRITE does not abort the frame in progress.
- `busy_o = (state==WRITE)`.

## Timing
- Reset values:
  - all outputs 0;
  - `state=IDLE`, `seq=0`, FIFO empty, `drop_cnt_o=0`.
  - Reset mid-frame discards the partial frame and all FIFO contents.
- Write sequence, with strobe accepted at edge k:
  - header written at edge k+1;
  - channel c written at edge k+2+c;
  - last word written at edge k+`NUM_CH`+1.
- `busy_o` is high from after edge k until after edge k+`NUM_CH`+1.
- Any strobe sampled while `busy_o` is high is dropped and counted.
  - Minimum accepted strobe spacing is therefore `NUM_CH+2` cycles.
- Latency: with the FIFO empty and `m_tready_i` held high, the header is presented (`m_tvalid_o` high) in the cycle after edge k+1. Strobe-to-header latency is 2 cycles.
- Throughput: 1 word/cycle on both sides.
- `level_o` updates on the edge of each write or read.

## Test plan
- Default parameters, channels = c+1, one `sync_i`, ready held high:
  - stream is 0xA5000000, 1, 2, …, 8;
  - tvalid is high 9 consecutive cycles starting 2 cycles after the strobe;
  - tlast is high only on the word 8.
- Three strobes 10 cycles apart:
  - headers are 0xA5000000, 0xA5000001, 0xA5000002;
  - `drop_cnt_o` stays 0.
- Second strobe 5 cycles after the first:
  - `drop_cnt_o` = 1;
  - only one frame appears on the stream.
- `m_tready_i` held low, strobes every 10 cycles:
  - the first 3 frames are accepted, filling 27 of 32 words;
  - the 4th and 5th are dropped, giving `drop_cnt_o` = 2;
  - after ready rises, exactly 27 words drain with correct tlast positions.
- Ready toggled randomly during a frame: data and tlast hold stable while valid is high and ready is low; no word is lost or duplicated.
- `rst_ni` asserted at `wi=4`:
  - all outputs 0 immediately;
  - after release, the next frame header is 0xA5000000;
  - `en_i` low with a strobe gives no frame and no drop count.

Source files
------------

// File: rtl/channel_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : channel_framer
//  Description : Snapshots NUM_CH channel words on a sync strobe and writes a
//                header plus one word per channel into a FWFT word FIFO.
//                The FIFO drains over a valid/ready stream with a last marker.
//                Frames that do not fit whole are dropped and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module channel_framer #(
  parameter int NUM_CH     = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic                          sync_i,
  input  logic [NUM_CH*DATA_W-1:0]      ch_data_i,
  output logic [DATA_W-1:0]             m_tdata_o,
  output logic                          m_tvalid_o,
  output logic                          m_tlast_o,
  input  logic                          m_tready_i,
  output logic                          busy_o,
  output logic [15:0]                   drop_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int WI_W  = $clog2(NUM_CH + 1);
  localparam int SEQ_W = DATA_W - 8;
  // Highest occupancy at which a whole frame still fits.
  localparam logic [LW-1:0]   C_MAX_LVL_ACC = LW'(FIFO_DEPTH - NUM_CH - 1);
  localparam logic [WI_W-1:0] C_WI_LAST     = WI_W'(NUM_CH);

  // Refuse to elaborate with a parameter set the framer cannot honour.
  generate
    if (NUM_CH < 1 || NUM_CH > 64 || DATA_W < 16 ||
        FIFO_DEPTH < NUM_CH + 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("channel_framer: illegal parameter set");
    end
  endgenerate

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic [WI_W-1:0]            wi_q, wi_d;
  logic [NUM_CH*DATA_W-1:0]   snap_q, snap_d;
  logic [SEQ_W-1:0]           seq_q, seq_d;
  logic [15:0]                drop_q, drop_d;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]              level_q, level_d;
  logic [DATA_W:0]            mem_q [FIFO_DEPTH];

  logic                       strobe;
  logic                       accept;
  logic                       wr_en;
  logic                       rd_en;
  logic [DATA_W-1:0]          wr_data;
  logic                       wr_last;
  logic [DATA_W:0]            rd_word;

  // Word to be written for the current index: header at 0, channel c at c+1.
  always_comb begin
    wr_data = {8'hA5, seq_q};
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(wi_q) == c + 1) begin
        wr_data = snap_q[c*DATA_W +: DATA_W];
      end
    end
    wr_last = (wi_q == C_WI_LAST);
  end

  // Writer next state: accept/reject strobes and step through the frame words.
  always_comb begin
    state_d = state_q;
    wi_d    = wi_q;
    snap_d  = snap_q;
    seq_d   = seq_q;
    drop_d  = drop_q;
    wr_en   = 1'b0;
    strobe  = en_i & sync_i;
    // Occupancy before this edge's read is used, so a concurrent read never
    // makes room for a frame.
    accept  = strobe & (state_q == S_IDLE) & (level_q <= C_MAX_LVL_ACC);
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          snap_d  = ch_data_i;
          wi_d    = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (wi_q == C_WI_LAST) begin
          state_d = S_IDLE;
          seq_d   = seq_q + 1'b1;
        end else begin
          wi_d = wi_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (strobe && !accept && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // Writer state register; reset discards any frame in progress.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      wi_q    <= '0;
      snap_q  <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      wi_q    <= wi_d;
      snap_q  <= snap_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
    end
  end

  // FIFO pointer and occupancy update; space is reserved at accept so no overflow.
  always_comb begin
    rd_en    = (level_q != '0) & m_tready_i;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FIFO control registers.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // FIFO storage: data plus tlast per entry, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {wr_last, wr_data};
    end
  end

  // First-word-fall-through read side; outputs forced to zero when empty.
  always_comb begin
    rd_word    = mem_q[rd_ptr_q];
    m_tvalid_o = (level_q != '0);
    m_tdata_o  = m_tvalid_o ? rd_word[DATA_W-1:0] : '0;
    m_tlast_o  = m_tvalid_o ? rd_word[DATA_W] : 1'b0;
  end

  assign busy_o     = (state_q == S_WRITE);
  assign drop_cnt_o = drop_q;
  assign level_o    = level_q;

endmodule
`default_nettype wire

// File: tb/tb_channel_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_channel_framer
//  Description : Self-checking bench for channel_framer with a queue-based
//                frame/word reference model and scenario tasks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_channel_framer;

  localparam int NUM_CH     = 8;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 32;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic                        clk = 1'b0;
  logic                        rst_ni;
  logic                        en_i;
  logic                        sync_i;
  logic [NUM_CH*DATA_W-1:0]    ch_data_i;
  logic [DATA_W-1:0]           m_tdata_o;
  logic                        m_tvalid_o;
  logic                        m_tlast_o;
  logic                        m_tready_i;
  logic                        busy_o;
  logic [15:0]                 drop_cnt_o;
  logic [LW-1:0]               level_o;

  channel_framer #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_ni    (rst_ni),
    .en_i      (en_i),
    .sync_i    (sync_i),
    .ch_data_i (ch_data_i),
    .m_tdata_o (m_tdata_o),
    .m_tvalid_o(m_tvalid_o),
    .m_tlast_o (m_tlast_o),
    .m_tready_i(m_tready_i),
    .busy_o    (busy_o),
    .drop_cnt_o(drop_cnt_o),
    .level_o   (level_o)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: words already in the FIFO, words of the accepted frame
  // still to be written, and everything that crossed the stream handshake.
  logic [DATA_W:0] fifo_q[$];
  logic [DATA_W:0] pend_q[$];
  logic [DATA_W:0] got_q[$];
  logic [23:0]     m_seq;
  logic [15:0]     m_drop;
  int              m_words;
  bit              mon_en;
  bit              prev_stall;
  logic [DATA_W:0] prev_word;
  bit              rd, acc, sync_eff;

  task automatic clear_model();
    fifo_q.delete();
    pend_q.delete();
    got_q.delete();
    m_seq      = '0;
    m_drop     = '0;
    m_words    = 0;
    prev_stall = 1'b0;
  endtask

  // Model step at each falling edge, predicting the effect of the next rising edge.
  always @(negedge clk) begin
    if (mon_en && rst_ni) begin
      rd = m_tvalid_o && m_tready_i;
      tests_run++;
      if (level_o !== LW'(fifo_q.size())) begin
        tests_failed++;
        $display("FAIL mon_level: got %0d expected %0d at %0t", level_o, fifo_q.size(), $time);
      end
      tests_run++;
      if (m_tvalid_o !== (fifo_q.size() != 0)) begin
        tests_failed++;
        $display("FAIL mon_tvalid: got %0b expected %0b at %0t", m_tvalid_o, fifo_q.size() != 0, $time);
      end
      if (m_tvalid_o && fifo_q.size() != 0) begin
        tests_run++;
        if ({m_tlast_o, m_tdata_o} !== fifo_q[0]) begin
          tests_failed++;
          $display("FAIL mon_word: got last=%0b data=%h expected last=%0b data=%h at %0t",
                   m_tlast_o, m_tdata_o, fifo_q[0][DATA_W], fifo_q[0][DATA_W-1:0], $time);
        end
      end
      tests_run++;
      if (busy_o !== (pend_q.size() != 0)) begin
        tests_failed++;
        $display("FAIL mon_busy: got %0b expected %0b at %0t", busy_o, pend_q.size() != 0, $time);
      end
      tests_run++;
      if (drop_cnt_o !== m_drop) begin
        tests_failed++;
        $display("FAIL mon_drop: got %0d expected %0d at %0t", drop_cnt_o, m_drop, $time);
      end
      if (prev_stall) begin
        tests_run++;
        if ({m_tlast_o, m_tdata_o} !== prev_word) begin
          tests_failed++;
          $display("FAIL mon_stable: got %h expected %h at %0t", {m_tlast_o, m_tdata_o}, prev_word, $time);
        end
      end
      prev_stall = m_tvalid_o && !m_tready_i;
      prev_word  = {m_tlast_o, m_tdata_o};

      sync_eff = en_i && sync_i;
      acc = sync_eff && (pend_q.size() == 0) && (FIFO_DEPTH - fifo_q.size() >= NUM_CH + 1);
      if (sync_eff && !acc && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      if (rd && fifo_q.size() != 0) got_q.push_back(fifo_q.pop_front());
      if (pend_q.size() != 0) fifo_q.push_back(pend_q.pop_front());
      if (acc) begin
        pend_q.push_back({1'b0, 8'hA5, m_seq});
        for (int c = 0; c < NUM_CH; c++) begin
          pend_q.push_back({(c == NUM_CH - 1), ch_data_i[c*DATA_W +: DATA_W]});
        end
        m_seq   = m_seq + 24'd1;
        m_words = m_words + NUM_CH + 1;
      end
    end
  end

  task automatic apply_reset();
    mon_en     = 1'b0;
    rst_ni     = 1'b0;
    en_i       = 1'b0;
    sync_i     = 1'b0;
    m_tready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    rst_ni = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic set_ramp();
    for (int c = 0; c < NUM_CH; c++) ch_data_i[c*DATA_W +: DATA_W] = DATA_W'(c + 1);
  endtask

  // Drive sync on the edges listed by cycle index within a window of n cycles.
  task automatic run_strobes(input int n, input int period, input int count);
    for (int cyc = 0; cyc < n; cyc++) begin
      @(posedge clk);
      #1;
      sync_i = (cyc % period == 0) && (cyc / period < count);
    end
    sync_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; en_i = 1'b0; sync_i = 1'b0; m_tready_i = 1'b0; mon_en = 1'b0;
    ch_data_i = '0;
    #3;
    tests_run++;
    if ({m_tvalid_o, m_tlast_o, busy_o} !== 3'b000 || m_tdata_o !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%0b l=%0b b=%0b d=%h expected all 0", m_tvalid_o, m_tlast_o, busy_o, m_tdata_o);
    end
    tests_run++;
    if (drop_cnt_o !== 16'd0 || level_o !== '0) begin
      tests_failed++;
      $display("FAIL reset_counts: got drop=%0d level=%0d expected 0 0", drop_cnt_o, level_o);
    end
    apply_reset();
    @(negedge clk);
    tests_run++;
    if (level_o !== '0 || m_tvalid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: got level=%0d valid=%0b expected 0 0", level_o, m_tvalid_o);
    end
  endtask

  task automatic test_single_frame();
    logic exp_v;
    logic [DATA_W-1:0] exp_d;
    apply_reset();
    set_ramp();
    en_i = 1'b1; m_tready_i = 1'b1;
    @(posedge clk); #1 sync_i = 1'b1;
    @(posedge clk); #1 sync_i = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      exp_v = (i >= 1 && i <= 9);
      exp_d = (i == 1) ? 32'hA500_0000 : DATA_W'(i - 1);
      tests_run++;
      if (m_tvalid_o !== exp_v) begin
        tests_failed++;
        $display("FAIL single_valid[%0d]: got %0b expected %0b", i, m_tvalid_o, exp_v);
      end
      if (exp_v) begin
        tests_run++;
        if (m_tdata_o !== exp_d || m_tlast_o !== (i == 9)) begin
          tests_failed++;
          $display("FAIL single_word[%0d]: got d=%h l=%0b expected d=%h l=%0b", i, m_tdata_o, m_tlast_o, exp_d, i == 9);
        end
      end
    end
  endtask

  task automatic test_three_strobes();
    logic [DATA_W:0] exp_h;
    apply_reset();
    set_ramp();
    en_i = 1'b1; m_tready_i = 1'b1;
    run_strobes(60, 10, 3);
    tests_run++;
    if (got_q.size() != 27) begin
      tests_failed++;
      $display("FAIL three_count: got %0d words expected 27", got_q.size());
    end else begin
      for (int f = 0; f < 3; f++) begin
        exp_h = {1'b0, 32'hA500_0000 + 32'(f)};
        tests_run++;
        if (got_q[f*9] !== exp_h) begin
          tests_failed++;
          $display("FAIL three_header[%0d]: got %h expected %h", f, got_q[f*9], exp_h);
        end
      end
    end
    tests_run++;
    if (drop_cnt_o !== 16'd0) begin
      tests_failed++;
      $display("FAIL three_drop: got %0d expected 0", drop_cnt_o);
    end
  endtask

  task automatic test_close_strobe();
    apply_reset();
    set_ramp();
    en_i = 1'b1; m_tready_i = 1'b1;
    run_strobes(40, 5, 2);
    tests_run++;
    if (drop_cnt_o !== 16'd1) begin
      tests_failed++;
      $display("FAIL close_drop: got %0d expected 1", drop_cnt_o);
    end
    tests_run++;
    if (got_q.size() != 9) begin
      tests_failed++;
      $display("FAIL close_count: got %0d words expected 9", got_q.size());
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_ramp();
    en_i = 1'b1; m_tready_i = 1'b0;
    run_strobes(50, 10, 5);
    tests_run++;
    if (level_o !== LW'(27)) begin
      tests_failed++;
      $display("FAIL bp_level: got %0d expected 27", level_o);
    end
    tests_run++;
    if (drop_cnt_o !== 16'd2) begin
      tests_failed++;
      $display("FAIL bp_drop: got %0d expected 2", drop_cnt_o);
    end
    @(posedge clk); #1 m_tready_i = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    tests_run++;
    if (got_q.size() != 27) begin
      tests_failed++;
      $display("FAIL bp_drain: got %0d words expected 27", got_q.size());
    end else begin
      for (int i = 0; i < 27; i++) begin
        tests_run++;
        if (got_q[i][DATA_W] !== (i % 9 == 8)) begin
          tests_failed++;
          $display("FAIL bp_tlast[%0d]: got %0b expected %0b", i, got_q[i][DATA_W], i % 9 == 8);
        end
      end
    end
  endtask

  task automatic test_random_ready();
    int waited;
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++) ch_data_i[c*DATA_W +: DATA_W] = $urandom;
      m_tready_i = ($urandom_range(0, 2) != 0);
      en_i       = ($urandom_range(0, 7) != 0);
      sync_i     = ($urandom_range(0, 5) == 0);
    end
    sync_i = 1'b0; m_tready_i = 1'b1;
    waited = 0;
    while ((fifo_q.size() != 0 || pend_q.size() != 0) && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    tests_run++;
    if (fifo_q.size() != 0 || pend_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rand_drain_timeout: got %0d words left expected 0", fifo_q.size() + pend_q.size());
    end
    @(negedge clk);
    tests_run++;
    if (got_q.size() != m_words || level_o !== '0) begin
      tests_failed++;
      $display("FAIL rand_total: got %0d words level=%0d expected %0d words level=0", got_q.size(), level_o, m_words);
    end
  endtask

  task automatic test_reset_midframe();
    int n_before;
    apply_reset();
    set_ramp();
    en_i = 1'b1; m_tready_i = 1'b0;
    @(posedge clk); #1 sync_i = 1'b1;
    @(posedge clk); #1 sync_i = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    tests_run++;
    if (busy_o !== 1'b1 || level_o !== LW'(4)) begin
      tests_failed++;
      $display("FAIL mid_prereset: got busy=%0b level=%0d expected 1 4", busy_o, level_o);
    end
    mon_en = 1'b0;
    rst_ni = 1'b0;
    #1;
    tests_run++;
    if ({m_tvalid_o, m_tlast_o, busy_o} !== 3'b000 || m_tdata_o !== '0 ||
        drop_cnt_o !== 16'd0 || level_o !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got v=%0b l=%0b b=%0b d=%h drop=%0d level=%0d expected all 0",
               m_tvalid_o, m_tlast_o, busy_o, m_tdata_o, drop_cnt_o, level_o);
    end
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    rst_ni = 1'b1; mon_en = 1'b1; m_tready_i = 1'b1;
    run_strobes(20, 100, 1);
    tests_run++;
    if (got_q.size() != 9 || got_q[0] !== {1'b0, 32'hA500_0000}) begin
      tests_failed++;
      $display("FAIL mid_next_header: got %0d words first=%h expected 9 words first=%h",
               got_q.size(), (got_q.size() != 0) ? got_q[0] : '0, {1'b0, 32'hA500_0000});
    end
    n_before = got_q.size();
    en_i = 1'b0;
    run_strobes(20, 100, 1);
    tests_run++;
    if (got_q.size() != n_before || drop_cnt_o !== 16'd0) begin
      tests_failed++;
      $display("FAIL en_low_strobe: got %0d new words drop=%0d expected 0 0", got_q.size() - n_before, drop_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_three_strobes();
    test_close_strobe();
    test_backpressure();
    test_random_ready();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
